// File: rtl/rm_pkg.sv
// Shared types for the runtime-monitor lane path: violation kinds,
// lane FSM states and the report record carried to the output stream.
package rm_pkg;

    localparam int RM_NUM_LANES  = 5;
    localparam int RM_NUM_EVENTS = 10;
    localparam int RM_LANE_W     = $clog2(RM_NUM_LANES);
    localparam int RM_EV_W       = $clog2(RM_NUM_EVENTS);

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        TIMEOUT      = 2'd1,
        DOUBLE_OPEN  = 2'd2,
        ORPHAN_CLOSE = 2'd3
    } rm_viol_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPORT = 2'd2
    } rm_lane_state_e;

    typedef struct packed {
        logic [RM_LANE_W-1:0] lane;
        rm_viol_e             kind;
        logic [RM_EV_W-1:0]   ev0;
        logic [RM_EV_W-1:0]   ev1;
    } rm_report_t;

endpackage

// File: rtl/rm_rr_arbiter.sv
// Round-robin arbiter: search starts at the lane after the last one granted;
// the pointer only moves when the grant is actually taken.
module rm_rr_arbiter #(
    parameter int NUM_LANES = 5,
    parameter int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_LANES-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_LANES-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic             found;
    int               j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            j = int'(last_q) + k;
            if (j >= NUM_LANES) j = j - NUM_LANES;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDX_W'(j);
            end
        end
    end

    // Reset to the last lane so lane 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_q <= IDX_W'(NUM_LANES - 1);
        else if (advance_i && found)
            last_q <= gnt_idx_o;
    end

endmodule

// File: rtl/rm_lane_monitor.sv
// Per-lane open/close pairing monitor; violations are serialised through
// a round-robin arbiter into one registered valid/ready report stream.
module rm_lane_monitor
    import rm_pkg::*;
#(
    parameter int NUM_LANES  = RM_NUM_LANES,
    parameter int NUM_EVENTS = RM_NUM_EVENTS,
    parameter int WIN_W      = 8,
    parameter int CNT_W      = 16,
    parameter int LANE_W     = $clog2(NUM_LANES),
    parameter int EV_W       = $clog2(NUM_EVENTS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  en_i,
    input  logic [WIN_W-1:0]                      cfg_window_i,
    input  logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  lane_vector0_i,
    input  logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  lane_vector1_i,
    input  logic [NUM_LANES-1:0][EV_W-1:0]        itype1_i,
    input  logic [NUM_LANES-1:0]                  valid0_i,
    input  logic [NUM_LANES-1:0]                  valid1_i,
    output logic                                  report_valid_o,
    input  logic                                  report_ready_i,
    output logic [LANE_W-1:0]                     report_lane_o,
    output logic [1:0]                            report_kind_o,
    output logic [EV_W-1:0]                       report_ev0_o,
    output logic [EV_W-1:0]                       report_ev1_o,
    output logic [NUM_LANES-1:0]                  lost_o,
    output logic [NUM_LANES-1:0][CNT_W-1:0]       pairs_o
);

    rm_report_t           rec [NUM_LANES];
    logic [NUM_LANES-1:0] req, ack, gnt, owner_q;
    logic [LANE_W-1:0]    gnt_idx;
    logic                 rpt_valid_q, load;
    rm_report_t           rpt_q;
    logic                 unused_parity;

    assign unused_parity = ^lane_vector1_i;
    assign load          = !rpt_valid_q || report_ready_i;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rm_lane_state_e   state_q, state_d;
        logic [WIN_W-1:0] cnt_q, cnt_d;
        logic [EV_W-1:0]  open_q, open_d, first_set;
        rm_report_t       rec_q, rec_d;
        logic [CNT_W-1:0] pairs_q, pairs_d;
        logic             lost_q, lost_d;
        logic             v0, v1;

        assign v0 = en_i && valid0_i[i];
        assign v1 = en_i && valid1_i[i];

        always_comb begin
            first_set = '0;
            for (int b = NUM_EVENTS - 1; b >= 0; b--)
                if (lane_vector0_i[i][b]) first_set = EV_W'(b);
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            open_d  = open_q;
            rec_d   = rec_q;
            pairs_d = pairs_q;
            lost_d  = lost_q;
            unique case (state_q)
                IDLE: begin
                    if (v0) begin
                        open_d  = first_set;
                        cnt_d   = cfg_window_i;
                        state_d = ARMED;
                    end else if (v1) begin
                        rec_d = '{lane: RM_LANE_W'(i), kind: ORPHAN_CLOSE,
                                  ev0: '0, ev1: RM_EV_W'(itype1_i[i])};
                        state_d = REPORT;
                    end
                end
                ARMED: begin
                    if (!en_i) begin
                        state_d = IDLE;
                    end else if (v1) begin
                        if (pairs_q != '1) pairs_d = pairs_q + CNT_W'(1);
                        if (v0) begin
                            open_d = first_set;
                            cnt_d  = cfg_window_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (v0) begin
                        rec_d = '{lane: RM_LANE_W'(i), kind: DOUBLE_OPEN,
                                  ev0: RM_EV_W'(open_q), ev1: '0};
                        state_d = REPORT;
                    end else if (cfg_window_i != '0) begin
                        // <=1 also catches a window enabled after arming with 0
                        if (cnt_q <= WIN_W'(1)) begin
                            rec_d = '{lane: RM_LANE_W'(i), kind: TIMEOUT,
                                      ev0: RM_EV_W'(open_q), ev1: '0};
                            state_d = REPORT;
                        end else begin
                            cnt_d = cnt_q - WIN_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (v0 || v1) lost_d = 1'b1;
                    if (ack[i]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                open_q  <= '0;
                rec_q   <= '0;
                pairs_q <= '0;
                lost_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                open_q  <= open_d;
                rec_q   <= rec_d;
                pairs_q <= pairs_d;
                lost_q  <= lost_d;
            end
        end

        // The lane already sitting in the output register must not re-request.
        assign req[i]     = (state_q == REPORT) && !(rpt_valid_q && owner_q[i]);
        assign ack[i]     = rpt_valid_q && report_ready_i && owner_q[i];
        assign rec[i]     = rec_q;
        assign pairs_o[i] = pairs_q;
        assign lost_o[i]  = lost_q;
    end

    rm_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (LANE_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req),
        .advance_i (load),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_valid_q <= 1'b0;
            rpt_q       <= '0;
            owner_q     <= '0;
        end else if (load) begin
            rpt_valid_q <= |req;
            owner_q     <= gnt;
            if (|req) rpt_q <= rec[gnt_idx];
        end
    end

    assign report_valid_o = rpt_valid_q;
    assign report_lane_o  = LANE_W'(rpt_q.lane);
    assign report_kind_o  = rpt_q.kind;
    assign report_ev0_o   = EV_W'(rpt_q.ev0);
    assign report_ev1_o   = EV_W'(rpt_q.ev1);

endmodule

// File: tb/tb_rm_lane_monitor.sv
// Scoreboard bench for rm_lane_monitor: expected records are queued when
// stimulus is driven and compared on every report handshake.
module tb_rm_lane_monitor;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [7:0]        cfg;
    logic [4:0][9:0]   lv0, lv1;
    logic [4:0][3:0]   it1;
    logic [4:0]        v0, v1;
    logic              valid, ready;
    logic [2:0]        lane;
    logic [1:0]        kind;
    logic [3:0]        ev0, ev1;
    logic [4:0]        lost;
    logic [4:0][15:0]  pairs;

    typedef struct {
        int lane;
        int kind;
        int ev0;
        int ev1;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rm_lane_monitor dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .cfg_window_i   (cfg),
        .lane_vector0_i (lv0),
        .lane_vector1_i (lv1),
        .itype1_i       (it1),
        .valid0_i       (v0),
        .valid1_i       (v1),
        .report_valid_o (valid),
        .report_ready_i (ready),
        .report_lane_o  (lane),
        .report_kind_o  (kind),
        .report_ev0_o   (ev0),
        .report_ev1_o   (ev1),
        .lost_o         (lost),
        .pairs_o        (pairs)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rpt_lane", lane, e.lane);
                check("rpt_kind", kind, e.kind);
                check("rpt_ev0", ev0, e.ev0);
                check("rpt_ev1", ev1, e.ev1);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int l, input int k, input int a, input int b);
        sb.push_back('{lane: l, kind: k, ev0: a, ev1: b});
    endtask

    task automatic open1(input int l, input logic [9:0] vec);
        v0[l]  = 1'b1;
        lv0[l] = vec;
        cycle();
        v0[l]  = 1'b0;
        lv0[l] = '0;
    endtask

    task automatic close1(input int l, input int it);
        v1[l]  = 1'b1;
        it1[l] = 4'(it);
        cycle();
        v1[l]  = 1'b0;
        it1[l] = '0;
    endtask

    task automatic wait_valid(input int max);
        for (int k = 0; k < max && !valid; k++) cycle();
        check("wait_valid", valid, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) cycle();
        check("drain", sb.size(), 0);
        cycle();
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; cfg = 8'd4; ready = 1'b1;
        lv0 = '0; lv1 = '0; it1 = '0; v0 = '0; v1 = '0;
        repeat (3) cycle();
        check("rst_valid", valid, 0);
        check("rst_kind", kind, 0);
        check("rst_lost", lost, 0);
        check("rst_pairs", |pairs, 0);
        rst = 1'b0;
        cycle();

        // pairing, close three cycles after arm
        open1(2, 10'b0010001000);
        cycle();
        cycle();
        close1(2, 3);
        check("pair2", pairs[2], 1);
        check("pair2_noval", valid, 0);
        repeat (6) cycle();
        check("pair2_late", valid, 0);

        // close exactly at t+window is still accepted
        open1(3, 10'b1000000000);
        repeat (3) cycle();
        close1(3, 0);
        check("pair3_edge", pairs[3], 1);
        repeat (6) cycle();
        drain();

        // timeout: valid rises at t+window+1
        push(1, 1, 2, 0);
        open1(1, 10'b0001000100);
        repeat (4) cycle();
        check("to_early", valid, 0);
        cycle();
        check("to_valid", valid, 1);
        drain();

        // window 0 never times out
        cfg = 8'd0;
        open1(1, 10'b0000000001);
        repeat (20) cycle();
        check("win0_noval", valid, 0);
        close1(1, 0);
        check("win0_pair", pairs[1], 1);
        cfg = 8'd4;

        // double open reports the old opener
        push(0, 2, 5, 0);
        open1(0, 10'b0000100000);
        cycle();
        open1(0, 10'b0000000010);
        drain();

        // armed open+close together: pair and re-arm with new opener
        push(0, 1, 6, 0);
        open1(0, 10'b0000010000);
        cycle();
        v0[0] = 1'b1; lv0[0] = 10'b0001000000; v1[0] = 1'b1;
        cycle();
        v0[0] = 1'b0; lv0[0] = '0; v1[0] = 1'b0;
        check("sim_pair", pairs[0], 1);
        repeat (4) cycle();
        check("rearm_early", valid, 0);
        cycle();
        check("rearm_valid", valid, 1);
        drain();

        // orphan close
        push(4, 3, 0, 7);
        close1(4, 7);
        drain();

        // idle open+close together arms only
        v0[4] = 1'b1; lv0[4] = 10'b0000000100; v1[4] = 1'b1; it1[4] = 4'd5;
        cycle();
        v0[4] = 1'b0; lv0[4] = '0; v1[4] = 1'b0; it1[4] = '0;
        cycle();
        close1(4, 1);
        check("idle_sim_pair", pairs[4], 1);
        drain();

        // enable low while armed forces idle
        open1(2, 10'b0000000010);
        cycle();
        en = 1'b0;
        cycle();
        v1[2] = 1'b1;
        cycle();
        v1[2] = 1'b0;
        en = 1'b1;
        check("en_pairs_hold", pairs[2], 1);
        repeat (8) cycle();
        check("en_no_timeout", valid, 0);
        push(2, 3, 0, 4);
        close1(2, 4);
        drain();

        // asynchronous reset with a lane armed and a report pending
        open1(1, 10'b0000000001);
        ready = 1'b0;
        close1(4, 2);
        wait_valid(5);
        v0[4] = 1'b1;
        cycle();
        v0[4] = 1'b0;
        check("lost4_set", lost[4], 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_lost", lost, 0);
        check("arst_pairs", |pairs, 0);
        check("arst_kind", kind, 0);
        cycle();
        rst = 1'b0;
        ready = 1'b1;
        repeat (8) cycle();
        check("post_rst_idle", valid, 0);

        // simultaneous timeouts under backpressure, first grant after reset
        ready = 1'b0;
        push(0, 1, 1, 0);
        push(1, 1, 2, 0);
        push(3, 1, 9, 0);
        v0[0] = 1'b1; lv0[0] = 10'b0000000010;
        v0[1] = 1'b1; lv0[1] = 10'b0000000100;
        v0[3] = 1'b1; lv0[3] = 10'b1000000000;
        cycle();
        v0 = '0; lv0 = '0;
        wait_valid(10);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", valid, 1);
            check("bp_lane", lane, 0);
            check("bp_kind", kind, 1);
            check("bp_ev0", ev0, 1);
            if (k == 0) v0[3] = 1'b1;
            cycle();
            v0[3] = 1'b0;
        end
        check("lost3", lost, 5'b01000);
        ready = 1'b1;
        cycle();
        check("rr_second_v", valid, 1);
        check("rr_second", lane, 1);
        cycle();
        check("rr_third_v", valid, 1);
        check("rr_third", lane, 3);
        cycle();
        check("rr_done", valid, 0);
        drain();

        // rotation continues after lane 3
        push(4, 1, 0, 0);
        push(0, 1, 2, 0);
        v0[4] = 1'b1; lv0[4] = 10'b0000000001;
        v0[0] = 1'b1; lv0[0] = 10'b0000000100;
        cycle();
        v0 = '0; lv0 = '0;
        drain();

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rm_lane_monitor.md
Name: rm_lane_monitor

Overview:
- Sits directly downstream of rm_event_router in the runtime-monitor (RM) path.
- Runs one open/close pairing FSM per lane on the routed per-lane vectors: valid0/lane_vector0 opens a lane, valid1/itype1 closes it.
- Flags timeouts, double-opens and orphan closes.
- Violations are serialised into one valid/ready report stream via a round-robin arbiter.

Parameters:
- NUM_LANES, 5, number of monitor lanes; must match the router.
- NUM_EVENTS, 10, number of event probes; must match the router.
- WIN_W, 8, width of the timeout window counter.
- CNT_W, 16, width of the per-lane completed-pair counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- en_i  in  1  monitor enable
- cfg_window_i  in  WIN_W  close window in cycles; 0 disables timeout
- lane_vector0_i  in  NUM_LANES x NUM_EVENTS  opening-event bits per lane
- lane_vector1_i  in  NUM_LANES x NUM_EVENTS  closing-event bits per lane (parity only, not used for matching)
- itype1_i  in  NUM_LANES x clog2(NUM_EVENTS)  closer itype per lane
- valid0_i  in  NUM_LANES  open strobe per lane
- valid1_i  in  NUM_LANES  close strobe per lane
- report_valid_o  out  1  violation record valid
- report_ready_i  in  1  consumer accepts record
- report_lane_o  out  clog2(NUM_LANES)  lane index of the record
- report_kind_o  out  2  violation kind: 1=TIMEOUT, 2=DOUBLE_OPEN, 3=ORPHAN_CLOSE
- report_ev0_o  out  clog2(NUM_EVENTS)  captured opener index (0 for ORPHAN_CLOSE)
- report_ev1_o  out  clog2(NUM_EVENTS)  closer itype (0 for TIMEOUT)
- lost_o  out  NUM_LANES  sticky: event dropped while lane in REPORT
- pairs_o  out  NUM_LANES x CNT_W  saturating completed-pair count per lane

Behaviour:
- Reset: all outputs are 0; all lanes in IDLE.
- Per-lane FSM states: IDLE, ARMED, REPORT.
- IDLE:
  - valid0 -> capture opener = lowest set bit of lane_vector0; load counter = cfg_window; go to ARMED.
  - valid1 alone -> ORPHAN_CLOSE, capture itype1, go to REPORT.
  - valid0 and valid1 in the same cycle -> arm only; the close is ignored.
- ARMED, evaluated in this priority order:
  - valid1 -> pair complete; pairs += 1, saturating at all-ones. If valid0 is also high, re-arm with the new opener and reload the counter; otherwise go to IDLE.
  - valid0 without valid1 -> DOUBLE_OPEN; report the old opener index; go to REPORT.
  - Otherwise, if cfg_window != 0: counter == 1 -> TIMEOUT, go to REPORT; else decrement the counter.
  - Arm at cycle t: a close is accepted in cycles t+1 .. t+window. Timeout is detected at t+window; report_valid_o is high at t+window+1.
- REPORT:
  - The lane raises an arbiter request.
  - Any valid0 or valid1 arriving while in REPORT is dropped and sets lost_o[lane]. lost_o clears only on reset.
- Report stream:
  - Registered; report_valid_o rises the cycle after the lane enters REPORT.
  - Round-robin grant: start at the lane after the last granted lane; on the first grant after reset, lane 0 has priority.
  - Fields hold stable while valid && !ready.
  - On valid && ready the granted lane returns to IDLE. The next record can be valid the following cycle; one record per cycle maximum.
- en_i low:
  - IDLE and ARMED lanes are forced to IDLE next cycle; inputs are ignored.
  - REPORT lanes and the report register keep draining.
  - pairs_o and lost_o hold.
- Zero-latency path: a violation and a report handshake for the same lane in the same cycle is impossible, because a lane is in REPORT at least one cycle before its grant.

Decomposition:
- rm_pkg:
  - rm_viol_e enum (NONE, TIMEOUT, DOUBLE_OPEN, ORPHAN_CLOSE)
  - rm_report_t struct (lane, kind, ev0, ev1)
  - lane FSM state enum
- Sub-module rm_rr_arbiter, parameterised on NUM_LANES: request vector in, one-hot grant and index out, pointer advances on handshake.
- The per-lane FSM is a generate loop inside rm_lane_monitor.

Test Plan:
- Pairing: cfg_window=4; lane 2 valid0 with bit 3 at t=10, valid1 at t=13 -> no report; pairs_o[2]=1.
- Timeout: cfg_window=4; lane 1 armed at t=10, no close -> report_valid_o at t=15 with lane=1, kind=1, ev0 = opener index.
- Double-open and simultaneity:
  - Lane 0 armed (opener 5), then valid0 alone -> kind=2, ev0=5.
  - Armed lane gets valid0 and valid1 together -> pairs+1, re-armed, no report.
- Orphan: lane 4 idle, valid1 with itype1=7 -> kind=3, ev1=7, ev0=0.
- Arbitration and backpressure:
  - Lanes 0, 1, 3 time out in the same cycle with report_ready_i low for 5 cycles -> fields stable throughout.
  - Then order is 0, 1, 3 on consecutive cycles.
  - Extra valid0 to lane 3 while waiting -> lost_o[3]=1.
- Reset/enable:
  - rst_i asserted mid-ARMED and with a report pending -> all outputs 0 immediately, with no clock edge needed.
  - en_i low while armed -> no timeout is ever reported.
